forwarding_scoreboard: RTL and testbench
========================================

# forwarding_scoreboard

Parametrised forwarding and load-use interlock unit for the five-stage MIPS pipeline and its deeper variants. It keeps its own shift-register scoreboard of in-flight register writes for every stage after EX, so the pipeline registers no longer feed it destination tags. Each cycle it produces per-operand forwarding selects for the instruction in EX, a load-use stall request, and saturating performance counters. It sits beside the ID/EX register and drives the ALU operand muxes and the hazard/stall logic.

## Interface
- NSRC, 2: number of source operands checked for the EX instruction.
- FWD_STAGES, 2: number of post-EX stages that can forward; stage 1 = EX/MEM … stage FWD_STAGES = MEM/WB.
- LOAD_STAGE, 2: first stage at which load data is forwardable; legal range 1..FWD_STAGES.
- RAW, 5: register address width.
- CNTW, 32: performance counter width.
- SELW (derived), clog2(FWD_STAGES+1): per-operand select width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low; clears all state.
- hold  in  1  pipeline-wide freeze, e.g. memory wait. The scoreboard and counters do not change.
- ex_valid  in  1  an instruction is in EX.
- ex_regwrite  in  1  the EX instruction writes a register.
- ex_is_load  in  1  the EX instruction is a load.
- ex_rd  in  RAW  destination register of the EX instruction.
- ex_flush  in  1  kills the EX instruction; it is not pushed into the scoreboard.
- ex_src  in  NSRC*RAW  EX source registers; operand i is at bits [i*RAW +: RAW].
- fwd_sel  out  NSRC*SELW  per-operand select: 0 = register file, k = stage k.
- stall  out  1  load-use interlock request.
- is_forwarding  out  1  at least one fwd_sel is nonzero.
- stall_count  out  CNTW  saturating count of stall cycles.
- fwd_count  out  CNTW  saturating count of cycles with forwarding.

## Operation
- Scoreboard: FWD_STAGES entries, each holding {v, rd, ld}. Entry k describes the instruction currently in stage k.
- Push value:
  - v = ex_valid & ex_regwrite & ~ex_flush & ~stall & (ex_rd != 0).
  - rd = ex_rd.
  - ld = ex_is_load.
- Each edge with hold=0: entry[1] takes the push value and entry[k] takes entry[k-1] for k = 2..FWD_STAGES. The oldest entry drops out; the register file has been written by then.
- While stall=1, a bubble (v=0) enters entry[1] and the EX instruction stays in place.
- Operand match (combinational), for each operand i:
  - Find the lowest k with entry[k].v and entry[k].rd == src_i.
  - If src_i == 0, there is no match.
  - The nearest stage always wins, so older writers are shadowed.
- Load-use:
  - If the matched entry has ld=1 and k < LOAD_STAGE, the operand is not ready.
  - stall = ex_valid & (any operand not ready).
- fwd_sel:
  - If ex_valid=0 or stall=1, all fwd_sel = 0.
  - Otherwise fwd_sel_i = k of the match, or 0 if there is no match.
  - Multiple operands may forward in the same cycle from the same or different stages.
- hold does not mask the combinational outputs. They continue to reflect the current state and inputs.
- Counters, on an edge with hold=0:
  - stall_count increments if stall=1.
  - fwd_count increments if is_forwarding=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (rst_n low, asynchronous): all entry.v = 0 and both counters = 0. Hence fwd_sel = 0, stall = 0 and is_forwarding = 0 immediately.
- Latency: fwd_sel, stall and is_forwarding are combinational from inputs and state, in the same cycle. The scoreboard updates on the next rising edge.
- A producer pushed at edge t is visible as stage 1 in cycle t+1 and as stage k in cycle t+k, provided hold stays low. Each hold cycle delays this by one.
- With defaults, a load followed by a dependent instruction produces:
  - one stall cycle, then
  - fwd_sel = 2 on the next cycle.
- Simultaneous events:
  - hold=1 with stall=1: no state change and no count.
  - ex_flush=1 with stall=1: the push is a bubble either way.
  - rst_n assertion mid-operation discards all in-flight entries.
- The counter width bounds saturation; the counters have no clear other than reset.

## Test plan
- Reset: drive rst_n=0 mid-stream with entries valid. Then: outputs are 0, the counters are 0, and after release ex_src = {5,5} gives fwd_sel = 0.
- Back-to-back ALU chain: push rd=2, then EX srcs {2,3} gives fwd_sel = {0,1}. One cycle later, EX srcs {3,2} gives fwd_sel = {2,0}.
- Shadowing: push rd=4, then push rd=4 again. Then EX src 4 gives sel = 1, not 2. Two pushes before, with an unrelated push between, it gives sel = 2.
- Load-use: push ld rd=8, then EX src 8 gives stall=1 for exactly one cycle and stall_count = 1. The next cycle gives sel = 2 and stall = 0.
- Zero register and flush:
  - Push rd=0, then src 0 gives sel = 0.
  - Push rd=9 with ex_flush=1, then src 9 gives sel = 0.
- hold and saturation:
  - hold for 3 cycles after push rd=6: sel stays 1 with no shift and no count.
  - With CNTW=2, 5 stall cycles leave stall_count = 3.

Source files
------------

// File: rtl/forwarding_scoreboard.sv
// Forwarding select and load-use interlock for the EX stage, driven by a private
// shift-register record of in-flight register writes in the post-EX stages.

module fs_operand_match #(
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 2,
  parameter int RAW        = 5,
  parameter int SELW       = 2
) (
  input  logic [RAW-1:0]                  src,
  input  logic [FWD_STAGES-1:0]           ent_v,
  input  logic [FWD_STAGES-1:0][RAW-1:0]  ent_rd,
  input  logic [FWD_STAGES-1:0]           ent_ld,
  output logic [SELW-1:0]                 sel,
  output logic                            not_ready
);
  logic found;

  // Scan from stage 1 outward so the nearest writer shadows older ones.
  always_comb begin
    sel       = '0;
    not_ready = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      if (!found && ent_v[k] && (ent_rd[k] == src) && (src != '0)) begin
        found     = 1'b1;
        sel       = SELW'(k + 1);
        not_ready = ent_ld[k] && ((k + 1) < LOAD_STAGE);
      end
    end
  end
endmodule

module forwarding_scoreboard #(
  parameter  int NSRC       = 2,
  parameter  int FWD_STAGES = 2,
  parameter  int LOAD_STAGE = 2,
  parameter  int RAW        = 5,
  parameter  int CNTW       = 32,
  localparam int SELW       = $clog2(FWD_STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic                 ex_valid,
  input  logic                 ex_regwrite,
  input  logic                 ex_is_load,
  input  logic [RAW-1:0]       ex_rd,
  input  logic                 ex_flush,
  input  logic [NSRC*RAW-1:0]  ex_src,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic                 stall,
  output logic                 is_forwarding,
  output logic [CNTW-1:0]      stall_count,
  output logic [CNTW-1:0]      fwd_count
);
  // Index k-1 holds the instruction currently in post-EX stage k.
  logic [FWD_STAGES-1:0]           ent_v;
  logic [FWD_STAGES-1:0][RAW-1:0]  ent_rd;
  logic [FWD_STAGES-1:0]           ent_ld;

  logic [NSRC-1:0][SELW-1:0] op_sel;
  logic [NSRC-1:0]           op_nr;
  logic                      push_v;

  genvar i;
  generate
    for (i = 0; i < NSRC; i++) begin : g_op
      fs_operand_match #(
        .FWD_STAGES(FWD_STAGES), .LOAD_STAGE(LOAD_STAGE), .RAW(RAW), .SELW(SELW)
      ) u_match (
        .src       (ex_src[i*RAW +: RAW]),
        .ent_v     (ent_v),
        .ent_rd    (ent_rd),
        .ent_ld    (ent_ld),
        .sel       (op_sel[i]),
        .not_ready (op_nr[i])
      );
    end
  endgenerate

  assign stall         = ex_valid & (|op_nr);
  assign fwd_sel       = (ex_valid && !stall) ? op_sel : '0;
  assign is_forwarding = |fwd_sel;

  // A stalled EX instruction re-issues next cycle, so it pushes a bubble now.
  assign push_v = ex_valid & ex_regwrite & ~ex_flush & ~stall & (ex_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_v  <= '0;
      ent_rd <= '0;
      ent_ld <= '0;
    end else if (!hold) begin
      for (int k = FWD_STAGES - 1; k >= 1; k--) begin
        ent_v[k]  <= ent_v[k-1];
        ent_rd[k] <= ent_rd[k-1];
        ent_ld[k] <= ent_ld[k-1];
      end
      ent_v[0]  <= push_v;
      ent_rd[0] <= ex_rd;
      ent_ld[0] <= ex_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else if (!hold) begin
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (is_forwarding && (fwd_count != '1))
        fwd_count <= fwd_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUTs.

module tb_forwarding_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, ex_valid, ex_regwrite, ex_is_load, ex_flush;
  logic [4:0]  ex_rd;
  logic [9:0]  ex_src;
  logic [3:0]  fwd_sel, sat_sel;
  logic        stall, is_forwarding, sat_stall, sat_isf;
  logic [31:0] stall_count, fwd_count;
  logic [1:0]  sat_scnt, sat_fcnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      nm;
    logic [1:0] s0, s1;
    logic       st, isf;
    bit         cc;
    int         sc, fc;
    bit         sat;
    int         ssc, sfc;
  } exp_t;

  exp_t q[$];
  exp_t me;

  always #5 clk = ~clk;

  forwarding_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_flush(ex_flush), .ex_src(ex_src), .fwd_sel(fwd_sel), .stall(stall),
    .is_forwarding(is_forwarding), .stall_count(stall_count), .fwd_count(fwd_count)
  );

  forwarding_scoreboard #(.CNTW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .hold(hold), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_flush(ex_flush), .ex_src(ex_src), .fwd_sel(sat_sel), .stall(sat_stall),
    .is_forwarding(sat_isf), .stall_count(sat_scnt), .fwd_count(sat_fcnt)
  );

  task automatic chk(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk({me.nm, ".sel0"}, fwd_sel[1:0], me.s0);
      chk({me.nm, ".sel1"}, fwd_sel[3:2], me.s1);
      chk({me.nm, ".stall"}, stall, me.st);
      chk({me.nm, ".isfwd"}, is_forwarding, me.isf);
      if (me.cc) begin
        chk({me.nm, ".stall_count"}, stall_count, me.sc);
        chk({me.nm, ".fwd_count"}, fwd_count, me.fc);
      end
      if (me.sat) begin
        chk({me.nm, ".sat_sel"}, sat_sel, {me.s1, me.s0});
        chk({me.nm, ".sat_stall"}, sat_stall, me.st);
        chk({me.nm, ".sat_stall_count"}, sat_scnt, me.ssc);
        chk({me.nm, ".sat_fwd_count"}, sat_fcnt, me.sfc);
      end
    end
  end

  task automatic drive(bit v, bit rw, bit ld, logic [4:0] rd, bit fl,
                       logic [4:0] s0, logic [4:0] s1, bit h);
    ex_valid = v; ex_regwrite = rw; ex_is_load = ld; ex_rd = rd;
    ex_flush = fl; ex_src = {s1, s0}; hold = h;
  endtask

  task automatic expect_o(string nm, logic [1:0] s0, logic [1:0] s1, bit st,
                          bit cc = 0, int sc = 0, int fc = 0,
                          bit sat = 0, int ssc = 0, int sfc = 0);
    exp_t e;
    e.nm = nm; e.s0 = s0; e.s1 = s1; e.st = st; e.isf = (s0 != 0) || (s1 != 0);
    e.cc = cc; e.sc = sc; e.fc = fc; e.sat = sat; e.ssc = ssc; e.sfc = sfc;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_o("reset_init", 0, 0, 0, 1, 0, 0, 1, 0, 0);
    tick();
    rst_n = 1'b1;

    // Asynchronous reset mid-stream discards live entries
    drive(1, 1, 0, 5, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 7, 0, 5, 5, 0);
    expect_o("pre_reset", 1, 1, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 5, 7, 0);
    rst_n = 1'b0;
    expect_o("in_reset", 0, 0, 0, 1, 0, 0, 1, 0, 0); tick();
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 5, 5, 0);
    expect_o("post_reset", 0, 0, 0, 1, 0, 0); tick();

    // Back-to-back ALU chain
    reset_pulse();
    drive(1, 1, 0, 2, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 2, 3, 0);
    expect_o("chain_s1", 1, 0, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 3, 2, 0);
    expect_o("chain_s2", 0, 2, 0, 1, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_o("chain_drained", 0, 0, 0, 1, 0, 2); tick();

    // Shadowing: nearest writer wins
    reset_pulse();
    drive(1, 1, 0, 4, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 4, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 4, 0, 0);
    expect_o("shadow_near", 1, 0, 0); tick();
    reset_pulse();
    drive(1, 1, 0, 4, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 10, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 4, 10, 0);
    expect_o("shadow_far", 2, 1, 0); tick();

    // Load-use: one stall, then forward from stage 2
    reset_pulse();
    drive(1, 1, 1, 8, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 11, 0, 8, 0, 0);
    expect_o("lu_stall", 0, 0, 1, 1, 0, 0); tick();
    expect_o("lu_fwd", 2, 0, 0, 1, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 11, 8, 0);
    expect_o("lu_after", 1, 0, 0, 1, 1, 1); tick();

    // Zero register and flush
    reset_pulse();
    drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 9, 1, 0, 0, 0);
    expect_o("zero_reg", 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 9, 0, 0);
    expect_o("flushed", 0, 0, 0, 1, 0, 0); tick();

    // hold freezes state and counters, not the outputs
    reset_pulse();
    drive(1, 1, 0, 6, 0, 0, 0, 0); tick();
    for (int h = 0; h < 3; h++) begin
      drive(1, 1, 0, 12, 0, 6, 0, 1);
      expect_o($sformatf("hold%0d", h), 1, 0, 0, 1, 0, 0); tick();
    end
    drive(1, 0, 0, 0, 0, 6, 12, 0);
    expect_o("hold_release", 1, 0, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 6, 0, 0);
    expect_o("hold_shift", 2, 0, 0, 1, 0, 1); tick();

    // hold with stall, then saturation of the 2-bit counters
    reset_pulse();
    drive(1, 1, 1, 8, 0, 0, 0, 0); tick();
    for (int h = 0; h < 2; h++) begin
      drive(1, 1, 1, 8, 0, 8, 0, 1);
      expect_o($sformatf("hold_stall%0d", h), 0, 0, 1, 1, 0, 0, 1, 0, 0); tick();
    end
    for (int n = 0; n < 5; n++) begin
      drive(1, 1, 1, 8, 0, 8, 0, 0);
      expect_o($sformatf("sat_stall%0d", n), 0, 0, 1, 1, n, n,
               1, (n > 3) ? 3 : n, (n > 3) ? 3 : n);
      tick();
      expect_o($sformatf("sat_fwd%0d", n), 2, 0, 0, 1, n + 1, n,
               1, (n + 1 > 3) ? 3 : n + 1, (n > 3) ? 3 : n);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_o("sat_final", 0, 0, 0, 1, 5, 5, 1, 3, 3);
    tick();
    tick();

    if (q.size() != 0) begin
      errors++;
      $display("FAIL monitor_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
